// File: rtl/axi4lite_led_pkg.sv
// Shared constants and types for the AXI4-Lite LED register slave.
// Register map, LED mode encoding and response codes.
package axi4lite_led_pkg;

  localparam logic [3:0] REG_PATTERN = 4'h0;
  localparam logic [3:0] REG_MODE    = 4'h4;
  localparam logic [3:0] REG_PERIOD  = 4'h8;
  localparam logic [3:0] REG_SCRATCH = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    BLINK  = 2'd1,
    ROTATE = 2'd2
  } led_mode_e;

  function automatic logic [1:0] reg_idx(input logic [3:0] a);
    return a[3:2];
  endfunction

endpackage

// File: rtl/axi4lite_led_regs_slave_led_gen.sv
// LED pattern generator: tick counter, blink phase and rotate shifter.
// cfg_wr is a one-hot per register, pulsed the cycle after a write lands.
module led_pattern_gen
  import axi4lite_led_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [1:0]   mode,
  input  logic [N-1:0] pattern,
  input  logic [31:0]  period,
  input  logic [3:0]   cfg_wr,
  output logic [N-1:0] led
);

  logic [31:0]  cnt_q, cnt_d;
  logic         phase_q, phase_d;
  logic [N-1:0] rot_q, rot_d;
  logic [N-1:0] led_q, led_d;
  logic         tick, clr, mode_wr, reload;

  always_comb begin
    mode_wr = cfg_wr[reg_idx(REG_MODE)];
    clr     = mode_wr | cfg_wr[reg_idx(REG_PERIOD)];
    tick    = (cnt_q == period);
    cnt_d   = (clr || tick) ? '0 : cnt_q + 32'd1;
    phase_d = mode_wr ? 1'b0 : (tick ? ~phase_q : phase_q);
    reload  = mode_wr |
              (cfg_wr[reg_idx(REG_PATTERN)] & (mode == ROTATE));
    rot_d   = rot_q;
    if (reload)
      rot_d = pattern;
    else if (tick)
      rot_d = (rot_q << 1) | (rot_q >> (N - 1));
    led_d = pattern;
    unique case (1'b1)
      (mode == BLINK):  led_d = phase_q ? pattern : '0;
      (mode == ROTATE): led_d = rot_q;
      default:          led_d = pattern;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rot_q   <= '0;
      led_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rot_q   <= rot_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/axi4lite_led_regs_slave.sv
// AXI4-Lite slave with four 32-bit registers driving board LEDs.
// Holds the write/read channel FSMs and the register file.
module axi4lite_led_regs_slave
  import axi4lite_led_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_NUM_LEDS         = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_NUM_LEDS-1:0]           led
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [1:0]         wst_q, wst_d;
  logic [0:0]         rst_st_q, rst_st_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               arready_q, arready_d;
  logic [1:0]         awidx_q, awidx_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [SW-1:0]      wstrb_q, wstrb_d;
  logic [3:0][DW-1:0] regs_q, regs_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [3:0]         cfg_q, cfg_d;

  logic          aw_fire, w_fire, ar_fire, wr_en;
  logic [1:0]    widx;
  logic [DW-1:0] wd;
  logic [SW-1:0] ws;

  always_comb begin
    aw_fire = s00_axi_awvalid & awready_q;
    w_fire  = s00_axi_wvalid & wready_q;
    ar_fire = s00_axi_arvalid & arready_q;
    // Commit in the cycle the second half of the pair arrives.
    wr_en = (aw_fire | (wst_q == W_ADDR)) & (w_fire | (wst_q == W_DATA));
    widx  = (wst_q == W_ADDR) ? awidx_q : s00_axi_awaddr[3:2];
    wd    = (wst_q == W_DATA) ? wdata_q : s00_axi_wdata;
    ws    = (wst_q == W_DATA) ? wstrb_q : s00_axi_wstrb;

    wst_d = wst_q;
    if (wst_q == W_RESP) begin
      if (s00_axi_bready) wst_d = W_IDLE;
    end else if (wr_en) begin
      wst_d = W_RESP;
    end else if (aw_fire) begin
      wst_d = W_ADDR;
    end else if (w_fire) begin
      wst_d = W_DATA;
    end
    awready_d = (wst_d == W_IDLE) | (wst_d == W_DATA);
    wready_d  = (wst_d == W_IDLE) | (wst_d == W_ADDR);
    awidx_d   = aw_fire ? s00_axi_awaddr[3:2] : awidx_q;
    wdata_d   = w_fire ? s00_axi_wdata : wdata_q;
    wstrb_d   = w_fire ? s00_axi_wstrb : wstrb_q;

    regs_d = regs_q;
    cfg_d  = '0;
    if (wr_en) begin
      for (int b = 0; b < SW; b++)
        if (ws[b]) regs_d[widx][8*b +: 8] = wd[8*b +: 8];
      cfg_d[widx] = |ws;
    end

    rst_st_d = rst_st_q;
    rdata_d  = rdata_q;
    if (ar_fire) begin
      rst_st_d = R_DATA;
      rdata_d  = regs_q[s00_axi_araddr[3:2]];
    end else if ((rst_st_q == R_DATA) && s00_axi_rready) begin
      rst_st_d = R_IDLE;
    end
    arready_d = (rst_st_d == R_IDLE);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wst_q     <= W_IDLE;
      rst_st_q  <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      regs_q    <= '0;
      rdata_q   <= '0;
      cfg_q     <= '0;
    end else begin
      wst_q     <= wst_d;
      rst_st_q  <= rst_st_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      regs_q    <= regs_d;
      rdata_q   <= rdata_d;
      cfg_q     <= cfg_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = (wst_q == W_RESP);
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = (rst_st_q == R_DATA);
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = RESP_OKAY;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  led_pattern_gen #(.N(C_NUM_LEDS)) u_led_gen (
    .clk     (s00_axi_aclk),
    .rstn    (s00_axi_aresetn),
    .mode    (regs_q[reg_idx(REG_MODE)][1:0]),
    .pattern (regs_q[reg_idx(REG_PATTERN)][C_NUM_LEDS-1:0]),
    .period  (regs_q[reg_idx(REG_PERIOD)]),
    .cfg_wr  (cfg_q),
    .led     (led)
  );

endmodule

// File: tb/tb_axi4lite_led_regs_slave.sv
// Bench for axi4lite_led_regs_slave: vector table plus
// hand-written handshake, stall, LED timing and reset sequences.
module tb_axi4lite_led_regs_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [3:0]  led;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi4lite_led_regs_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_NUM_LEDS(4)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .led             (led)
  );

  typedef struct {
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int  n;
    bit  aw_p, w_p, h_aw, h_w;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; n = 0;
    while ((aw_p || w_p) && n < 20) begin
      h_aw = aw_p && awready;
      h_w  = w_p && wready;
      step();
      n++;
      if (h_aw) begin awvalid = 1'b0; aw_p = 1'b0; end
      if (h_w)  begin wvalid = 1'b0;  w_p = 1'b0;  end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake_pending", {31'b0, aw_p | w_p}, 32'd0);
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    check("wr_bvalid", {31'b0, bvalid}, 32'd1);
    check("wr_bresp", {30'b0, bresp}, 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin step(); n++; end
    check("rd_arready", {31'b0, arready}, 32'd1);
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    check("rd_rvalid", {31'b0, rvalid}, 32'd1);
    check("rd_rresp", {30'b0, rresp}, 32'd0);
    d = rdata;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic wait_led(input string nm, input logic [3:0] e);
    int n = 0;
    while (led !== e && n < 40) begin step(); n++; end
    check(nm, {28'b0, led}, {28'b0, e});
  endtask

  // led holds prev for three more cycles, then shows next
  task automatic led_step(input logic [3:0] prev, input logic [3:0] next);
    for (int i = 0; i < 3; i++) begin
      step();
      check("led_hold", {28'b0, led}, {28'b0, prev});
    end
    step();
    check("led_next", {28'b0, led}, {28'b0, next});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    tbl[0] = '{4'h0, 32'h0000_0001, 4'hF, 4'h0, 32'h0000_0001};
    tbl[1] = '{4'h4, 32'h0000_0002, 4'hF, 4'h4, 32'h0000_0002};
    tbl[2] = '{4'h8, 32'h0000_0003, 4'hF, 4'h8, 32'h0000_0003};
    tbl[3] = '{4'hC, 32'h0000_0004, 4'hF, 4'hC, 32'h0000_0004};
    tbl[4] = '{4'h0, 32'hAABB_CCDD, 4'b0101, 4'h0, 32'h00BB_00DD};
    tbl[5] = '{4'h0, 32'hFFFF_FFFF, 4'b0000, 4'h0, 32'h00BB_00DD};
    tbl[6] = '{4'hE, 32'h1234_5678, 4'hF, 4'hC, 32'h1234_5678};
    tbl[7] = '{4'hC, 32'hFFFF_FFFF, 4'b1010, 4'hC, 32'hFF34_FF78};
    tbl[8] = '{4'h0, 32'h1100_0000, 4'b1000, 4'h0, 32'h11BB_00DD};
    tbl[9] = '{4'h8, 32'h0000_0007, 4'b0001, 4'hB, 32'h0000_0007};

    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step();
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_wready", {31'b0, wready}, 32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_led", {28'b0, led}, 32'd0);
    #2 rst_n = 1'b1;
    step(); step();

    // write all four, then read all four
    for (int i = 0; i < 4; i++)
      axi_write(tbl[i].waddr, tbl[i].wdata, tbl[i].strb);
    for (int i = 0; i < 4; i++) begin
      axi_read(tbl[i].raddr, rd);
      check($sformatf("rd_vec%0d", i), rd, tbl[i].exp);
    end
    for (int i = 4; i < 10; i++) begin
      axi_write(tbl[i].waddr, tbl[i].wdata, tbl[i].strb);
      axi_read(tbl[i].raddr, rd);
      check($sformatf("rd_vec%0d", i), rd, tbl[i].exp);
    end

    // W two cycles ahead of AW
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("wfirst_awready", {31'b0, awready}, 32'd1);
    check("wfirst_wready", {31'b0, wready}, 32'd0);
    step();
    check("wfirst_nob", {31'b0, bvalid}, 32'd0);
    awaddr = 4'hC; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
    check("wfirst_awready_b", {31'b0, awready}, 32'd0);
    step();
    check("wfirst_bhold", {31'b0, bvalid}, 32'd1);
    check("wfirst_awready_b2", {31'b0, awready}, 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("wfirst_bdone", {31'b0, bvalid}, 32'd0);
    step();
    check("wfirst_single_b", {31'b0, bvalid}, 32'd0);
    axi_read(4'hC, rd);
    check("wfirst_data", rd, 32'h55);

    // AW two cycles ahead of W
    awaddr = 4'hC; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("awfirst_wready", {31'b0, wready}, 32'd1);
    check("awfirst_awready", {31'b0, awready}, 32'd0);
    step();
    check("awfirst_nob", {31'b0, bvalid}, 32'd0);
    wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("awfirst_bvalid", {31'b0, bvalid}, 32'd1);
    check("awfirst_awready_b", {31'b0, awready}, 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("awfirst_bdone", {31'b0, bvalid}, 32'd0);
    step();
    check("awfirst_single_b", {31'b0, bvalid}, 32'd0);
    axi_read(4'hC, rd);
    check("awfirst_data", rd, 32'h66);

    // same-cycle write and read of SCRATCH, then stall both responses
    awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF;
    araddr = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    wvalid = 1'b0;
    awaddr = 4'h0; araddr = 4'h0;
    check("rw_old_rdata", rdata, 32'h66);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_bvalid", {31'b0, bvalid}, 32'd1);
      check("stall_rvalid", {31'b0, rvalid}, 32'd1);
      check("stall_rdata", rdata, 32'h66);
      check("stall_awready", {31'b0, awready}, 32'd0);
      check("stall_arready", {31'b0, arready}, 32'd0);
    end
    awvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    check("stall_bdone", {31'b0, bvalid}, 32'd0);
    check("stall_rdone", {31'b0, rvalid}, 32'd0);
    axi_read(4'hC, rd);
    check("rw_new_data", rd, 32'h77);

    // rotate, then blink, with a 4-cycle tick
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    wait_led("rot_1", 4'h1);
    wait_led("rot_2", 4'h2);
    led_step(4'h2, 4'h4);
    led_step(4'h4, 4'h8);
    led_step(4'h8, 4'h1);
    axi_write(4'h4, 32'h1, 4'hF);
    wait_led("blink_0", 4'h0);
    wait_led("blink_1", 4'h1);
    led_step(4'h1, 4'h0);
    led_step(4'h0, 4'h1);

    // static, then reset while a write response is pending
    axi_write(4'h4, 32'h0, 4'hF);
    step(); step();
    check("static_led", {28'b0, led}, 32'd1);
    awaddr = 4'hC; wdata = 32'h99; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_bvalid", {31'b0, bvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bvalid", {31'b0, bvalid}, 32'd0);
    check("arst_led", {28'b0, led}, 32'd0);
    check("arst_awready", {31'b0, awready}, 32'd0);
    check("arst_arready", {31'b0, arready}, 32'd0);
    step(); step();
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      a = 4'(i * 4);
      axi_read(a, rd);
      check($sformatf("post_rst_reg%0d", i), rd, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
